avalon_irq_controller: RTL and testbench

- Avalon-MM slave interrupt controller directly downstream of the timer peripheral and other peripherals.
- Collects up to NUM_SOURCES interrupt request lines (timer irq on source 0), latches them as pending, masks and prioritises them.
- Drives a single registered CPU interrupt plus the ID of the highest-priority active source.
- Software services interrupts through a small register file on the same read_n/write_n bus style as the other peripherals.

---
 rtl/avalon_irq_controller.sv | 132 +++++++++++++
 tb/tb_avalon_irq_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_irq_controller.sv
// Avalon-MM interrupt controller: synchronises, latches, masks and prioritises
// up to NUM_SOURCES request lines into one registered CPU irq plus source id.
module avalon_irq_controller #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_n,
  input  logic                   write_n,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   irq,
  output logic [4:0]             irq_id
);

  localparam int unsigned N = NUM_SOURCES;

  localparam logic [2:0] OffPending = 3'd0;
  localparam logic [2:0] OffEnable  = 3'd1;
  localparam logic [2:0] OffEdge    = 3'd2;
  localparam logic [2:0] OffAck     = 3'd3;
  localparam logic [2:0] OffActive  = 3'd4;
  localparam logic [2:0] OffRaw     = 3'd5;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] enable_q, enable_d;
  logic [N-1:0] edge_q, edge_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         irq_q, irq_d;
  logic [4:0]   irq_id_q, irq_id_d;

  logic [N-1:0] s;
  logic [N-1:0] active;
  logic [N-1:0] ack;
  logic [2:0]   off;
  logic         rd_en, wr_en;
  logic         unused_bits;

  assign off         = address[4:2];
  assign rd_en       = ~read_n;
  assign wr_en       = ~write_n;
  assign unused_bits = ^{address[31:5], address[1:0], writeData};

  function automatic logic [31:0] widen(input logic [N-1:0] v);
    logic [31:0] w;
    w        = '0;
    w[N-1:0] = v;
    return w;
  endfunction

  always_comb begin
    sync_d[0] = irq_src;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign active = pending_q & enable_q;

  always_comb begin
    prev_d = s;
    ack    = (wr_en && off == OffAck) ? writeData[N-1:0] : '0;
    // Edge sources: a new edge beats a simultaneous ACK. Level sources follow s.
    pending_d = (edge_q & ((s & ~prev_q) | (pending_q & ~ack))) | (~edge_q & s);

    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_en && off == OffEnable) enable_d = writeData[N-1:0];
    if (wr_en && off == OffEdge)   edge_d   = writeData[N-1:0];
  end

  always_comb begin
    irq_d    = |active;
    irq_id_d = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (active[i]) irq_id_d = 5'(i);
    end
  end

  // Reads sample pre-write state so a simultaneous write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (off)
        OffPending: rdata_d = widen(pending_q);
        OffEnable:  rdata_d = widen(enable_q);
        OffEdge:    rdata_d = widen(edge_q);
        OffActive:  rdata_d = {irq_q, 26'b0, irq_id_q};
        OffRaw:     rdata_d = widen(s);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q    <= prev_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign readData = rdata_q;
  assign irq      = irq_q;
  assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_avalon_irq_controller.sv
// Directed plus randomised bench for avalon_irq_controller against a
// history-queue reference model of the register and interrupt behaviour.
module tb_avalon_irq_controller;

  localparam int unsigned N = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         read_n = 1'b1;
  logic         write_n = 1'b1;
  logic [31:0]  address = '0;
  logic [31:0]  writeData = '0;
  logic [31:0]  readData;
  logic [N-1:0] irq_src = '0;
  logic         irq;
  logic [4:0]   irq_id;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_en, m_edge;
  logic         m_irq;
  logic [4:0]   m_id;
  logic [31:0]  m_rd;
  logic [N-1:0] srcq[$];  // srcq[k] = irq_src sampled k+1 edges ago

  avalon_irq_controller #(
    .NUM_SOURCES(N),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read_n   (read_n),
    .write_n  (write_n),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .irq_src  (irq_src),
    .irq      (irq),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lowest(input logic [N-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_edge = '0;
    m_irq = 1'b0; m_id = '0; m_rd = '0;
    srcq = {};
    for (int k = 0; k <= S; k++) srcq.push_back('0);
  endtask

  task automatic model_step();
    logic [N-1:0] s, p, ack, act, nxt;
    logic [2:0]   off;
    s   = srcq[S-1];
    p   = srcq[S];
    off = address[4:2];
    if (!read_n) begin
      case (off)
        3'd0:    m_rd = 32'(m_pend);
        3'd1:    m_rd = 32'(m_en);
        3'd2:    m_rd = 32'(m_edge);
        3'd4:    m_rd = {m_irq, 26'b0, m_id};
        3'd5:    m_rd = 32'(s);
        default: m_rd = '0;
      endcase
    end
    act   = m_pend & m_en;
    m_irq = (act != 0);
    m_id  = lowest(act);
    ack   = (!write_n && off == 3'd3) ? writeData[N-1:0] : '0;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) nxt[i] = (s[i] && !p[i]) || (m_pend[i] && !ack[i]);
      else           nxt[i] = s[i];
    end
    m_pend = nxt;
    if (!write_n && off == 3'd1) m_en   = writeData[N-1:0];
    if (!write_n && off == 3'd2) m_edge = writeData[N-1:0];
    srcq.push_front(irq_src);
    void'(srcq.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("readData", readData, m_rd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_reg(input logic [2:0] off, input logic [31:0] d);
    address = {27'b0, off, 2'b0}; writeData = d; write_n = 1'b0;
    tick();
    write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [2:0] off, output logic [31:0] d);
    address = {27'b0, off, 2'b0}; read_n = 1'b0;
    tick();
    read_n = 1'b1;
    d = readData;
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  offs [7];
    offs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    model_reset();
    ticks(3);
    #2 rst = 1'b1;

    // Reset values across the map
    for (int k = 0; k < 7; k++) begin
      read_reg(offs[k], rd);
      check($sformatf("rd_reset_off%0d", offs[k]), rd, 32'h0);
    end

    // Single edge on the timer source
    write_reg(3'd1, 32'h01);
    write_reg(3'd2, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    ticks(2);
    check("t0_irq_early", 32'(irq), 32'h0);
    tick();
    check("t0_irq_4cyc", 32'(irq), 32'h1);
    check("t0_id", 32'(irq_id), 32'h0);
    read_reg(3'd0, rd);
    check("t0_pending", rd, 32'h01);
    write_reg(3'd3, 32'h01);
    check("t0_irq_after_ack_edge", 32'(irq), 32'h1);
    tick();
    check("t0_irq_cleared", 32'(irq), 32'h0);

    // Priority between sources 2 and 5
    write_reg(3'd1, 32'hFF);
    write_reg(3'd2, 32'hFF);
    irq_src = 8'h24;
    ticks(5);
    check("prio_id2", 32'(irq_id), 32'h2);
    read_reg(3'd4, rd);
    check("prio_active", rd, 32'h8000_0002);
    write_reg(3'd3, 32'h04);
    tick();
    check("prio_id5", 32'(irq_id), 32'h5);
    write_reg(3'd3, 32'h20);
    tick();
    check("prio_irq0", 32'(irq), 32'h0);
    irq_src = 8'h00;
    ticks(3);

    // Level mode on source 3
    write_reg(3'd2, 32'h00);
    write_reg(3'd1, 32'h08);
    irq_src = 8'h08;
    ticks(5);
    check("lvl_irq", 32'(irq), 32'h1);
    check("lvl_id", 32'(irq_id), 32'h3);
    write_reg(3'd3, 32'h08);
    read_reg(3'd0, rd);
    check("lvl_pend_after_ack", rd, 32'h08);
    irq_src = 8'h00;
    ticks(3);
    check("lvl_irq_hold", 32'(irq), 32'h1);
    tick();
    check("lvl_irq_drop", 32'(irq), 32'h0);

    // Edge arriving in the same cycle as its ACK
    write_reg(3'd2, 32'h02);
    write_reg(3'd1, 32'h02);
    irq_src = 8'h02; tick(); irq_src = 8'h00;
    ticks(5);
    check("race_irq_pre", 32'(irq), 32'h1);
    irq_src = 8'h02; tick(); irq_src = 8'h00;
    tick();
    write_reg(3'd3, 32'h02);
    ticks(2);
    check("race_irq_stays", 32'(irq), 32'h1);
    read_reg(3'd0, rd);
    check("race_pending", rd, 32'h02);
    write_reg(3'd3, 32'h02);
    ticks(2);

    // Masked pending, then enable, then async reset
    write_reg(3'd2, 32'h10);
    write_reg(3'd1, 32'h00);
    irq_src = 8'h10; tick(); irq_src = 8'h00;
    ticks(5);
    read_reg(3'd0, rd);
    check("mask_pending", rd, 32'h10);
    check("mask_irq", 32'(irq), 32'h0);
    write_reg(3'd1, 32'h10);
    tick();
    check("unmask_irq", 32'(irq), 32'h1);
    check("unmask_id", 32'(irq_id), 32'h4);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_irq_async", 32'(irq), 32'h0);
    check("rst_rdata_async", readData, 32'h0);
    ticks(2);
    #2 rst = 1'b1;
    read_reg(3'd0, rd);
    check("rst_pending", rd, 32'h0);
    read_reg(3'd1, rd);
    check("rst_enable", rd, 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ N'($urandom);
      read_n    = ($urandom_range(0, 1) == 0);
      write_n   = ($urandom_range(0, 3) != 0);
      address   = $urandom;
      writeData = $urandom;
      tick();
    end
    read_n  = 1'b1;
    write_n = 1'b1;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
